// File: rtl/lpm_hint_eval.sv
// lpm_hint_eval: streaming lookup of one NAME=VALUE binding inside a
// comma-separated hint string delivered one character per cycle.
// The result (found/value/val_ovf) is held from the done pulse until
// the next accepted start.
module lpm_hint_eval #(
  parameter int MAX_KEY_CHARS = 32,
  parameter int MAX_VAL_CHARS = 5
) (
  input  logic                       clock,
  input  logic                       sclr,
  input  logic                       start,
  input  logic [8*MAX_KEY_CHARS-1:0] key,
  input  logic [7:0]                 hint_char,
  input  logic                       hint_valid,
  input  logic                       hint_last,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [8*MAX_VAL_CHARS-1:0] value,
  output logic                       val_ovf
);

  localparam int KW  = 8 * MAX_KEY_CHARS;
  localparam int VW  = 8 * MAX_VAL_CHARS;
  // Name length saturates one past the limit so an over-long name is remembered.
  localparam int NLW = $clog2(MAX_KEY_CHARS + 2);
  localparam int VLW = $clog2(MAX_VAL_CHARS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NAME  = 3'd1,
    S_VALUE = 3'd2,
    S_SKIP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [KW-1:0]    key_r;
  logic [KW-1:0]    name_r;
  logic [NLW-1:0]   name_len_r;
  logic [VW-1:0]    value_r;
  logic [VLW-1:0]   val_len_r;
  logic             found_r;
  logic             val_ovf_r;
  logic             busy_r;
  logic             done_r;

  logic             char_ign_s;
  logic             is_eq_s;
  logic             is_comma_s;
  logic             name_match_s;
  logic             accept_s;
  state_t           char_nxt_s;

  assign char_ign_s   = (hint_char == 8'h20) || (hint_char == 8'h00);
  assign is_eq_s      = (hint_char == 8'h3D);
  assign is_comma_s   = (hint_char == 8'h2C);
  // Both buffers are right-justified with zero padding, so a plain vector
  // compare is exact; empty and over-long names are excluded explicitly.
  assign name_match_s = (name_len_r != {NLW{1'b0}}) &&
                        (name_len_r <= NLW'(MAX_KEY_CHARS)) &&
                        (name_r == key_r);
  assign accept_s     = hint_valid &&
                        ((state_r == S_NAME) || (state_r == S_VALUE) || (state_r == S_SKIP));

  // State that the current character leads to, before end-of-string handling.
  always_comb begin
    char_nxt_s = state_r;
    case (state_r)
      S_NAME: begin
        if (!char_ign_s && is_eq_s) begin
          char_nxt_s = name_match_s ? S_VALUE : S_SKIP;
        end else begin
          char_nxt_s = S_NAME;
        end
      end
      S_VALUE: begin
        if (!char_ign_s && is_comma_s) begin
          char_nxt_s = S_SKIP;
        end else begin
          char_nxt_s = S_VALUE;
        end
      end
      S_SKIP: begin
        if (!char_ign_s && is_comma_s && !found_r) begin
          char_nxt_s = S_NAME;
        end else begin
          char_nxt_s = S_SKIP;
        end
      end
      default: char_nxt_s = state_r;
    endcase
  end

  // Query FSM, character buffers and registered result outputs.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_r    <= S_IDLE;
      key_r      <= {KW{1'b0}};
      name_r     <= {KW{1'b0}};
      name_len_r <= {NLW{1'b0}};
      value_r    <= {VW{1'b0}};
      val_len_r  <= {VLW{1'b0}};
      found_r    <= 1'b0;
      val_ovf_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= S_NAME;
            busy_r     <= 1'b1;
            key_r      <= key;
            name_r     <= {KW{1'b0}};
            name_len_r <= {NLW{1'b0}};
            value_r    <= {VW{1'b0}};
            val_len_r  <= {VLW{1'b0}};
            found_r    <= 1'b0;
            val_ovf_r  <= 1'b0;
          end
        end
        S_NAME, S_VALUE, S_SKIP: begin
          if (accept_s) begin
            if (!char_ign_s) begin
              case (state_r)
                S_NAME: begin
                  if (is_comma_s) begin
                    name_r     <= {KW{1'b0}};
                    name_len_r <= {NLW{1'b0}};
                  end else if (!is_eq_s) begin
                    name_r <= {name_r[KW-9:0], hint_char};
                    if (name_len_r <= NLW'(MAX_KEY_CHARS)) begin
                      name_len_r <= name_len_r + NLW'(1);
                    end
                  end
                end
                S_VALUE: begin
                  if (is_comma_s) begin
                    found_r <= 1'b1;
                  end else begin
                    // Shift register keeps the most recent characters on overflow.
                    value_r <= {value_r[VW-9:0], hint_char};
                    if (val_len_r == VLW'(MAX_VAL_CHARS)) begin
                      val_ovf_r <= 1'b1;
                    end else begin
                      val_len_r <= val_len_r + VLW'(1);
                    end
                  end
                end
                S_SKIP: begin
                  if (is_comma_s && !found_r) begin
                    name_r     <= {KW{1'b0}};
                    name_len_r <= {NLW{1'b0}};
                  end
                end
                default: ;
              endcase
            end
            if (hint_last) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              // A string ending inside the matched value still counts as found.
              if (char_nxt_s == S_VALUE) begin
                found_r <= 1'b1;
              end
            end else begin
              state_r <= char_nxt_s;
            end
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign found   = found_r;
  assign value   = value_r;
  assign val_ovf = val_ovf_r;

endmodule

// File: tb/tb_lpm_hint_eval.sv
// Self-checking bench for lpm_hint_eval: table of queries plus hand-written
// reset / restart sequences; results are scored through an expected queue.
module tb_lpm_hint_eval;

  localparam int KC = 32;
  localparam int VC = 5;
  localparam int KW = 8 * KC;
  localparam int VW = 8 * VC;

  logic          clock = 1'b0;
  logic          sclr;
  logic          start;
  logic [KW-1:0] key;
  logic [7:0]    hint_char;
  logic          hint_valid;
  logic          hint_last;
  logic          busy;
  logic          done;
  logic          found;
  logic [VW-1:0] value;
  logic          val_ovf;

  lpm_hint_eval #(.MAX_KEY_CHARS(KC), .MAX_VAL_CHARS(VC)) dut (
    .clock      (clock),
    .sclr       (sclr),
    .start      (start),
    .key        (key),
    .hint_char  (hint_char),
    .hint_valid (hint_valid),
    .hint_last  (hint_last),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .value      (value),
    .val_ovf    (val_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    string k;
    string h;
    bit    f;
    string v;
    bit    o;
  } vec_t;

  typedef struct packed {
    logic          f;
    logic [VW-1:0] v;
    logic          o;
  } exp_t;

  vec_t tbl[13];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [KW-1:0] pack_key(string s);
    logic [KW-1:0] kv;
    kv = '0;
    for (int i = 0; i < s.len(); i++) kv = {kv[KW-9:0], s[i]};
    return kv;
  endfunction

  function automatic logic [VW-1:0] pack_val(string s);
    logic [VW-1:0] vv;
    vv = '0;
    for (int i = 0; i < s.len(); i++) vv = {vv[VW-9:0], s[i]};
    return vv;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse is matched against the oldest expected result.
  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending query");
      end else begin
        e = sb_q.pop_front();
        check("found", {63'd0, found}, {63'd0, e.f});
        check("value", {24'd0, value}, {24'd0, e.v});
        check("val_ovf", {63'd0, val_ovf}, {63'd0, e.o});
      end
    end
  end

  task automatic run_query(input string k, input string h, input int restart_at, input exp_t e);
    int n;
    n = (h.len() == 0) ? 1 : h.len();
    @(posedge clock); #1;
    key        = pack_key(k);
    start      = 1'b1;
    // A character offered in the start cycle must be ignored.
    hint_char  = 8'h51;
    hint_valid = 1'b1;
    hint_last  = 1'b1;
    sb_q.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < n; i++) begin
      hint_char  = (h.len() == 0) ? 8'h00 : h[i];
      hint_valid = 1'b1;
      hint_last  = (i == n - 1);
      start      = (i == restart_at);
      if (i == restart_at) key = pack_key("ZZ");
      @(posedge clock); #1;
    end
    hint_valid = 1'b0;
    hint_last  = 1'b0;
    start      = 1'b0;
    check("done_latency", {63'd0, done}, 64'd1);
    check("busy_drop", {63'd0, busy}, 64'd0);
    @(posedge clock); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("value_hold", {24'd0, value}, {24'd0, e.v});
  endtask

  initial begin
    string k32;
    exp_t  e;
    k32 = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345";
    tbl[0]  = '{k: "LPM_REMAINDERPOSITIVE", h: "LPM_REMAINDERPOSITIVE=TRUE", f: 1'b1, v: "TRUE", o: 1'b0};
    tbl[1]  = '{k: "LPM_REMAINDERPOSITIVE", h: "A=1, LPM_REMAINDERPOSITIVE = FALSE", f: 1'b1, v: "FALSE", o: 1'b0};
    tbl[2]  = '{k: "B", h: "X=Y,BB=3", f: 1'b0, v: "", o: 1'b0};
    tbl[3]  = '{k: "B", h: "B=", f: 1'b1, v: "", o: 1'b0};
    tbl[4]  = '{k: "K", h: "K=AB,K=CD", f: 1'b1, v: "AB", o: 1'b0};
    tbl[5]  = '{k: "K", h: "K=ABCDEFG", f: 1'b1, v: "CDEFG", o: 1'b1};
    tbl[6]  = '{k: "K", h: "", f: 1'b0, v: "", o: 1'b0};
    tbl[7]  = '{k: "k", h: "K=1", f: 1'b0, v: "", o: 1'b0};
    tbl[8]  = '{k: "K", h: "K=a=b", f: 1'b1, v: "a=b", o: 1'b0};
    tbl[9]  = '{k: "A", h: "AB=1,A=2", f: 1'b1, v: "2", o: 1'b0};
    tbl[10] = '{k: "", h: "=5", f: 1'b0, v: "", o: 1'b0};
    tbl[11] = '{k: "K", h: ",,K=7", f: 1'b1, v: "7", o: 1'b0};
    tbl[12] = '{k: k32, h: {"X", k32, "=1,", k32, "=9"}, f: 1'b1, v: "9", o: 1'b0};

    sclr = 1'b1; start = 1'b0; key = '0;
    hint_char = 8'h00; hint_valid = 1'b0; hint_last = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    sclr = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_found", {63'd0, found}, 64'd0);
    check("rst_value", {24'd0, value}, 64'd0);
    check("rst_val_ovf", {63'd0, val_ovf}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      e.f = tbl[i].f;
      e.v = pack_val(tbl[i].v);
      e.o = tbl[i].o;
      run_query(tbl[i].k, tbl[i].h, -1, e);
    end

    // Abort mid-stream: no done, everything back to reset values.
    @(posedge clock); #1;
    key = pack_key("K"); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    hint_valid = 1'b1;
    hint_char = 8'h4B; @(posedge clock); #1;
    hint_char = 8'h3D; @(posedge clock); #1;
    hint_char = 8'h31; @(posedge clock); #1;
    hint_valid = 1'b0;
    check("busy_mid", {63'd0, busy}, 64'd1);
    sclr = 1'b1;
    @(posedge clock); #1;
    sclr = 1'b0;
    check("sclr_busy", {63'd0, busy}, 64'd0);
    check("sclr_done", {63'd0, done}, 64'd0);
    check("sclr_found", {63'd0, found}, 64'd0);
    check("sclr_value", {24'd0, value}, 64'd0);
    check("sclr_val_ovf", {63'd0, val_ovf}, 64'd0);
    // A last character while idle must not produce a done pulse.
    hint_char = 8'h32; hint_valid = 1'b1; hint_last = 1'b1;
    @(posedge clock); #1;
    hint_valid = 1'b0; hint_last = 1'b0;
    @(posedge clock); #1;
    check("idle_no_done", {63'd0, done}, 64'd0);

    e.f = 1'b1; e.v = pack_val("Z"); e.o = 1'b0;
    run_query("K", "K=Z", -1, e);

    // start while busy is ignored; the original key is kept.
    e.f = 1'b1; e.v = pack_val("AB"); e.o = 1'b0;
    run_query("K", "K=AB,ZZ=CD", 3, e);
    e.f = 1'b1; e.v = pack_val("CD"); e.o = 1'b0;
    run_query("ZZ", "K=AB,ZZ=CD", 2, e);

    // A held result is cleared by sclr while idle.
    sclr = 1'b1;
    @(posedge clock); #1;
    sclr = 1'b0;
    check("hold_sclr_found", {63'd0, found}, 64'd0);
    check("hold_sclr_value", {24'd0, value}, 64'd0);

    repeat (3) @(posedge clock);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
